// File: rtl/game_select_sequencer.sv
// Game-select pushbutton sequencer: debounced presses advance a pending index that is committed
// after an idle settle window, with a CPU reset pulse on change. `GAME_SEL_HEX_EN adds a 7-seg readout.
module game_select_sequencer #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SETTLE_CYCLES   = 50000000,
    parameter int RESET_CYCLES    = 1024,
    parameter int NUM_GAMES       = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       count_in,
    output logic [3:0] game_out,
    output logic [3:0] pending_game,
    output logic       reset_cpu,
`ifdef GAME_SEL_HEX_EN
    output logic [6:0] hex_digit,
`endif
    output logic       busy
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int ST_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int HD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [ST_W-1:0] ST_LAST   = ST_W'(SETTLE_CYCLES - 1);
    localparam logic [HD_W-1:0] HD_LAST   = HD_W'(RESET_CYCLES - 1);
    localparam logic [3:0]      GAME_LAST = 4'(NUM_GAMES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PENDING,
        RESET_HOLD
    } state_t;

    state_t            state;
    logic              sync_p0;
    logic              sync_p1;
    logic              db_level;
    logic [DB_W-1:0]   db_cnt;
    logic [ST_W-1:0]   settle_cnt;
    logic [HD_W-1:0]   hold_cnt;
    logic              press;
    logic [3:0]        next_pending;

    // A press is the cycle in which the debounced level is about to flip from 0 to 1.
    assign press        = sync_p1 && !db_level && (db_cnt == DB_LAST);
    assign next_pending = (pending_game == GAME_LAST) ? 4'd0 : pending_game + 4'd1;

    // Stage p0/p1: metastability synchroniser, then debounce on the p1 sample
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0  <= 1'b0;
            sync_p1  <= 1'b0;
            db_level <= 1'b0;
            db_cnt   <= '0;
        end else begin
            sync_p0 <= count_in;
            sync_p1 <= sync_p0;
            if (sync_p1 == db_level) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                db_level <= sync_p1;
                db_cnt   <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

    // Sequencer: pending index, settle window, commit and reset hold
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            pending_game <= 4'd0;
            game_out     <= 4'd0;
            reset_cpu    <= 1'b0;
            busy         <= 1'b0;
            settle_cnt   <= '0;
            hold_cnt     <= '0;
        end else begin
            if (press) begin
                pending_game <= next_pending;
            end
            case (state)
                IDLE: begin
                    if (press) begin
                        state      <= PENDING;
                        busy       <= 1'b1;
                        settle_cnt <= ST_LAST;
                    end
                end
                PENDING: begin
                    if (press) begin
                        settle_cnt <= ST_LAST;
                    end else if (settle_cnt == '0) begin
                        if (pending_game != game_out) begin
                            game_out  <= pending_game;
                            reset_cpu <= 1'b1;
                            hold_cnt  <= HD_LAST;
                            state     <= RESET_HOLD;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        settle_cnt <= settle_cnt - ST_W'(1);
                    end
                end
                RESET_HOLD: begin
                    if (hold_cnt == '0) begin
                        reset_cpu <= 1'b0;
                        // A press landing on the final hold cycle still needs a settle window.
                        if (press || (pending_game != game_out)) begin
                            state      <= PENDING;
                            settle_cnt <= ST_LAST;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        hold_cnt <= hold_cnt - HD_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef GAME_SEL_HEX_EN
    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'h0: seg7 = 7'b1000000;
            4'h1: seg7 = 7'b1111001;
            4'h2: seg7 = 7'b0100100;
            4'h3: seg7 = 7'b0110000;
            4'h4: seg7 = 7'b0011001;
            4'h5: seg7 = 7'b0010010;
            4'h6: seg7 = 7'b0000010;
            4'h7: seg7 = 7'b1111000;
            4'h8: seg7 = 7'b0000000;
            4'h9: seg7 = 7'b0010000;
            4'hA: seg7 = 7'b0001000;
            4'hB: seg7 = 7'b0000011;
            4'hC: seg7 = 7'b1000110;
            4'hD: seg7 = 7'b0100001;
            4'hE: seg7 = 7'b0000110;
            default: seg7 = 7'b0001110;
        endcase
    endfunction

    // Display stage: one cycle behind pending_game
    always_ff @(posedge clk) begin
        if (rst) begin
            hex_digit <= 7'b1000000;
        end else begin
            hex_digit <= seg7(pending_game);
        end
    end
`endif

endmodule

// File: tb/tb_game_select_sequencer.sv
// Bench for game_select_sequencer: directed scenarios plus random button activity, compared
// every cycle against an event/deadline-based reference model.
module tb_game_select_sequencer;

    localparam int DC = 4;
    localparam int S  = 20;
    localparam int R  = 8;
    localparam int NG = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       count_in = 1'b0;
    logic [3:0] game_out;
    logic [3:0] pending_game;
    logic       reset_cpu;
    logic       busy;
`ifdef GAME_SEL_HEX_EN
    logic [6:0] hex_digit;
    logic [6:0] m_hex;
`endif

    always #5 clk = ~clk;

    game_select_sequencer #(
        .DEBOUNCE_CYCLES(DC),
        .SETTLE_CYCLES  (S),
        .RESET_CYCLES   (R),
        .NUM_GAMES      (NG)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .count_in    (count_in),
        .game_out    (game_out),
        .pending_game(pending_game),
        .reset_cpu   (reset_cpu),
`ifdef GAME_SEL_HEX_EN
        .hex_digit   (hex_digit),
`endif
        .busy        (busy)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state: absolute-cycle deadlines instead of countdowns
    int         cyc = 0;
    bit         in_hist[$];
    bit         sync_hist[$];
    bit         m_level;
    logic [3:0] m_pend;
    logic [3:0] m_game;
    bit         m_rcpu;
    bit         m_busy;
    int         deadline = -1;
    int         hold_end = -1;
    bit         edge_rst;

    // Observation bookkeeping
    logic [3:0] prev_pend_obs = 4'd0;
    logic [3:0] prev_game_obs = 4'd0;
    int         pend_chg_cyc = 0;
    int         game_chg_cyc = 0;
    bit         saw_reset = 1'b0;
    int         plen = 0;
    int         npulses = 0;

`ifdef GAME_SEL_HEX_EN
    function automatic logic [6:0] seg(input logic [3:0] v);
        case (v)
            4'h0: seg = 7'b1000000; 4'h1: seg = 7'b1111001; 4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000; 4'h4: seg = 7'b0011001; 4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010; 4'h7: seg = 7'b1111000; 4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000; 4'hA: seg = 7'b0001000; 4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110; 4'hD: seg = 7'b0100001; 4'hE: seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
    endfunction
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, got, exp, cyc);
        end
    endtask

    task automatic model_step(input bit x, input bit r);
        bit synced;
        bit press;
        bit all_diff;
        cyc++;
        edge_rst = r;
        if (r) begin
            in_hist.delete();
            sync_hist.delete();
            m_level  = 1'b0;
            m_pend   = 4'd0;
            m_game   = 4'd0;
            m_rcpu   = 1'b0;
            m_busy   = 1'b0;
            deadline = -1;
            hold_end = -1;
`ifdef GAME_SEL_HEX_EN
            m_hex = 7'b1000000;
`endif
            return;
        end
`ifdef GAME_SEL_HEX_EN
        m_hex = seg(m_pend);
`endif
        // Button sample seen by the debouncer is the input from two edges ago.
        synced = (in_hist.size() >= 2) ? in_hist[in_hist.size()-2] : 1'b0;
        sync_hist.push_back(synced);
        if (sync_hist.size() > DC) void'(sync_hist.pop_front());
        press = 1'b0;
        if (sync_hist.size() == DC) begin
            all_diff = 1'b1;
            foreach (sync_hist[i]) if (sync_hist[i] == m_level) all_diff = 1'b0;
            if (all_diff) begin
                m_level = ~m_level;
                press   = m_level;
                sync_hist.delete();
            end
        end
        in_hist.push_back(x);
        if (in_hist.size() > 2) void'(in_hist.pop_front());

        if (hold_end >= 0) begin
            if (cyc == hold_end) begin
                m_rcpu   = 1'b0;
                hold_end = -1;
                if (m_pend != m_game || press) deadline = cyc + S;
            end
        end else if (deadline >= 0) begin
            if (press) begin
                deadline = cyc + S;
            end else if (cyc == deadline) begin
                deadline = -1;
                if (m_pend != m_game) begin
                    m_game   = m_pend;
                    m_rcpu   = 1'b1;
                    hold_end = cyc + R;
                end
            end
        end else if (press) begin
            deadline = cyc + S;
        end
        if (press) m_pend = (int'(m_pend) + 1) % NG;
        m_busy = (deadline >= 0) || (hold_end >= 0);
    endtask

    task automatic compare();
        check("game_out", 32'(game_out), 32'(m_game));
        check("pending_game", 32'(pending_game), 32'(m_pend));
        check("reset_cpu", 32'(reset_cpu), 32'(m_rcpu));
        check("busy", 32'(busy), 32'(m_busy));
`ifdef GAME_SEL_HEX_EN
        check("hex_digit", 32'(hex_digit), 32'(m_hex));
`endif
        if (pending_game !== prev_pend_obs) pend_chg_cyc = cyc;
        if (game_out !== prev_game_obs) game_chg_cyc = cyc;
        prev_pend_obs = pending_game;
        prev_game_obs = game_out;
        if (reset_cpu === 1'b1) begin
            saw_reset = 1'b1;
            plen++;
        end else begin
            if (plen > 0 && !edge_rst) begin
                check("reset_cpu_len", 32'(plen), 32'(R));
                npulses++;
            end
            plen = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(count_in, rst);
        #1;
        compare();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic press_pulse(input int hi, input int lo);
        count_in = 1'b1;
        ticks(hi);
        count_in = 1'b0;
        ticks(lo);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ticks(2);
        rst = 1'b0;
    endtask

    task automatic wait_reset_high(input int budget);
        int k;
        k = 0;
        while (reset_cpu !== 1'b1 && k < budget) begin
            tick();
            k++;
        end
        check("wait_reset_cpu", 32'(reset_cpu), 32'd1);
    endtask

    initial begin
        int tot;
        int len;
        rst = 1'b1;
        count_in = 1'b0;
        ticks(3);
        check("rst_game_out", 32'(game_out), 32'd0);
        check("rst_pending", 32'(pending_game), 32'd0);
        check("rst_reset_cpu", 32'(reset_cpu), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        ticks(2);

        // Bounce filtering
        for (int i = 0; i < 20; i++) begin
            count_in = ((i / 2) % 2) == 0;
            tick();
        end
        count_in = 1'b0;
        ticks(10);
        check("bounce_pending", 32'(pending_game), 32'd0);
        check("bounce_busy", 32'(busy), 32'd0);

        // Single clean press
        count_in = 1'b1;
        ticks(5);
        check("press_before", 32'(pending_game), 32'd0);
        tick();
        check("press_at_6", 32'(pending_game), 32'd1);
        ticks(4);
        count_in = 1'b0;
        ticks(40);
        check("single_game", 32'(game_out), 32'd1);
        check("single_latency", 32'(game_chg_cyc - pend_chg_cyc), 32'(S));
        check("single_idle", 32'(busy), 32'd0);

        // Wrap back to the committed game
        do_reset();
        saw_reset = 1'b0;
        press_pulse(5, 5);
        check("wrap_p1", 32'(pending_game), 32'd1);
        press_pulse(5, 5);
        check("wrap_p2", 32'(pending_game), 32'd2);
        press_pulse(5, 40);
        check("wrap_pending", 32'(pending_game), 32'd0);
        check("wrap_game", 32'(game_out), 32'd0);
        check("wrap_no_reset", 32'(saw_reset), 32'd0);
        check("wrap_idle", 32'(busy), 32'd0);

        // Second press inside the settle window restarts it
        do_reset();
        press_pulse(5, 10);
        press_pulse(5, 40);
        check("resettle_game", 32'(game_out), 32'd2);
        check("resettle_latency", 32'(game_chg_cyc - pend_chg_cyc), 32'(S));

        // Press during reset hold
        do_reset();
        npulses = 0;
        press_pulse(5, 18);
        press_pulse(5, 60);
        check("hold_game", 32'(game_out), 32'd2);
        check("hold_pulses", 32'(npulses), 32'd2);
        check("hold_idle", 32'(busy), 32'd0);

        // Reset asserted mid-hold
        do_reset();
        press_pulse(5, 0);
        wait_reset_high(60);
        ticks(3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_game", 32'(game_out), 32'd0);
        check("midrst_pending", 32'(pending_game), 32'd0);
        check("midrst_reset_cpu", 32'(reset_cpu), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
`ifdef GAME_SEL_HEX_EN
        check("midrst_hex", 32'(hex_digit), 32'h40);
`endif

        // Random button activity with occasional resets
        tot = 0;
        while (tot < 3000) begin
            len = $urandom_range(1, 30);
            count_in = 1'($urandom_range(0, 1));
            rst = ($urandom_range(0, 49) == 0);
            if (rst) len = 1;
            ticks(len);
            rst = 1'b0;
            tot += len;
        end
        count_in = 1'b0;
        ticks(80);
        check("final_idle", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
